// File: rtl/s9234_scan_pkg.sv
// Shared sizing and cell-index constants for the s9234 wrapper boundary register.
package s9234_scan_pkg;

  localparam int unsigned NUM_PI   = 36;
  localparam int unsigned NUM_PO   = 39;
  localparam int unsigned WBR_LEN  = NUM_PI + NUM_PO;
  localparam int unsigned PI_FIRST = 0;
  localparam int unsigned PI_LAST  = NUM_PI - 1;
  localparam int unsigned PO_FIRST = NUM_PI;
  localparam int unsigned PO_LAST  = WBR_LEN - 1;

endpackage

// File: rtl/s9234.sv
// Behavioural stand-in for the s9234 core: same pin list and clocking, no reset.
// Replace with the gate-level s9234 netlist in the production build.
module s9234 (
  input  logic CK,
  input  logic g89, g94, g98, g102, g107, g301, g306, g310, g314, g319,
  input  logic g557, g558, g559, g560, g561, g562, g563, g564,
  input  logic g705, g639, g567, g45, g42, g39, g702, g32,
  input  logic g38, g46, g36, g47, g40, g37, g41, g22, g44, g23,
  output logic g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137, g5468, g5469, g5692,
  output logic g6282, g6284, g6360, g6362, g6364, g6366, g6368, g6370, g6372, g6374,
  output logic g6728, g1290, g4121, g4108, g4106, g4103, g1293, g4099, g4102, g4109,
  output logic g4100, g4112, g4105, g4101, g4110, g4104, g4107, g4098
);

  logic [35:0] w_pi;
  logic [38:0] w_po;
  logic [35:0] r_a;
  logic [35:0] r_b;

  assign w_pi = {g23, g44, g22, g41, g37, g40, g47, g36, g46, g38,
                 g32, g702, g39, g42, g45, g567, g639, g705,
                 g564, g563, g562, g561, g560, g559, g558, g557,
                 g319, g314, g310, g306, g301, g107, g102, g98, g94, g89};

  always_ff @(posedge CK) begin
    r_a <= w_pi;
    r_b <= r_a ^ {w_pi[0], w_pi[35:1]};
  end

  assign w_po = {r_b, 3'b000} ^ {3'b000, w_pi & ~r_a} ^ {r_a[2:0], r_a};

  assign {g4098, g4107, g4104, g4110, g4101, g4105, g4112, g4100,
          g4109, g4102, g4099, g1293, g4103, g4106, g4108, g4121, g1290, g6728,
          g6374, g6372, g6370, g6368, g6366, g6364, g6362, g6360, g6284, g6282,
          g5692, g5469, g5468, g5137, g4809, g4422, g4321, g4307, g3600, g3222, g2584} = w_po;

endmodule

// File: rtl/s9234_scan_wbr_cell.sv
// One wrapper boundary cell: functional capture or serial shift into an async-reset flop.
module wbr_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scan_en,
  input  logic i_scan_in,
  input  logic i_func,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_scan_en ? i_scan_in : i_func;
  end

  assign o_q = r_q;

endmodule

// File: rtl/s9234_scan_top.sv
// Scan-wrapped s9234: 75-cell WBR around the unmodified core, one serial scan port.
// Define SCAN_LOCKUP_EN to retime scan_out through a negedge lockup flop.
module s9234_scan_top
  import s9234_scan_pkg::*;
(
  input  logic CK,
  input  logic rst_n,
  input  logic scan_in,
  output logic scan_out,
  input  logic scan_en,
  input  logic g89, g94, g98, g102, g107, g301, g306, g310, g314, g319,
  input  logic g557, g558, g559, g560, g561, g562, g563, g564,
  input  logic g705, g639, g567, g45, g42, g39, g702, g32,
  input  logic g38, g46, g36, g47, g40, g37, g41, g22, g44, g23,
  output logic g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137, g5468, g5469, g5692,
  output logic g6282, g6284, g6360, g6362, g6364, g6366, g6368, g6370, g6372, g6374,
  output logic g6728, g1290, g4121, g4108, g4106, g4103, g1293, g4099, g4102, g4109,
  output logic g4100, g4112, g4105, g4101, g4110, g4104, g4107, g4098
);

  logic [NUM_PI-1:0]  w_dev_pi;
  logic [NUM_PI-1:0]  w_core_pi;
  logic [NUM_PO-1:0]  w_core_po;
  logic [NUM_PO-1:0]  w_dev_po;
  logic [WBR_LEN-1:0] w_wbr;
  logic [WBR_LEN-1:0] w_chain_in;
  logic [WBR_LEN-1:0] w_capture;

  // Bit i of each vector is WBR cell i: PIs first (g89 = cell 0), then POs.
  assign w_dev_pi = {g23, g44, g22, g41, g37, g40, g47, g36, g46, g38,
                     g32, g702, g39, g42, g45, g567, g639, g705,
                     g564, g563, g562, g561, g560, g559, g558, g557,
                     g319, g314, g310, g306, g301, g107, g102, g98, g94, g89};

  assign w_core_pi  = scan_en ? w_wbr[PI_LAST:PI_FIRST] : w_dev_pi;
  assign w_dev_po   = scan_en ? w_wbr[PO_LAST:PO_FIRST] : w_core_po;
  assign w_chain_in = {w_wbr[WBR_LEN-2:0], scan_in};
  assign w_capture  = {w_core_po, w_dev_pi};

  assign {g4098, g4107, g4104, g4110, g4101, g4105, g4112, g4100,
          g4109, g4102, g4099, g1293, g4103, g4106, g4108, g4121, g1290, g6728,
          g6374, g6372, g6370, g6368, g6366, g6364, g6362, g6360, g6284, g6282,
          g5692, g5469, g5468, g5137, g4809, g4422, g4321, g4307, g3600, g3222, g2584} = w_dev_po;

  for (genvar i = 0; i < WBR_LEN; i++) begin : g_wbr
    wbr_cell u_cell (
      .i_clk     (CK),
      .i_rst_n   (rst_n),
      .i_scan_en (scan_en),
      .i_scan_in (w_chain_in[i]),
      .i_func    (w_capture[i]),
      .o_q       (w_wbr[i])
    );
  end

  s9234 u_core (
    .CK    (CK),
    .g89   (w_core_pi[0]),  .g94   (w_core_pi[1]),  .g98   (w_core_pi[2]),  .g102  (w_core_pi[3]),
    .g107  (w_core_pi[4]),  .g301  (w_core_pi[5]),  .g306  (w_core_pi[6]),  .g310  (w_core_pi[7]),
    .g314  (w_core_pi[8]),  .g319  (w_core_pi[9]),  .g557  (w_core_pi[10]), .g558  (w_core_pi[11]),
    .g559  (w_core_pi[12]), .g560  (w_core_pi[13]), .g561  (w_core_pi[14]), .g562  (w_core_pi[15]),
    .g563  (w_core_pi[16]), .g564  (w_core_pi[17]), .g705  (w_core_pi[18]), .g639  (w_core_pi[19]),
    .g567  (w_core_pi[20]), .g45   (w_core_pi[21]), .g42   (w_core_pi[22]), .g39   (w_core_pi[23]),
    .g702  (w_core_pi[24]), .g32   (w_core_pi[25]), .g38   (w_core_pi[26]), .g46   (w_core_pi[27]),
    .g36   (w_core_pi[28]), .g47   (w_core_pi[29]), .g40   (w_core_pi[30]), .g37   (w_core_pi[31]),
    .g41   (w_core_pi[32]), .g22   (w_core_pi[33]), .g44   (w_core_pi[34]), .g23   (w_core_pi[35]),
    .g2584 (w_core_po[0]),  .g3222 (w_core_po[1]),  .g3600 (w_core_po[2]),  .g4307 (w_core_po[3]),
    .g4321 (w_core_po[4]),  .g4422 (w_core_po[5]),  .g4809 (w_core_po[6]),  .g5137 (w_core_po[7]),
    .g5468 (w_core_po[8]),  .g5469 (w_core_po[9]),  .g5692 (w_core_po[10]), .g6282 (w_core_po[11]),
    .g6284 (w_core_po[12]), .g6360 (w_core_po[13]), .g6362 (w_core_po[14]), .g6364 (w_core_po[15]),
    .g6366 (w_core_po[16]), .g6368 (w_core_po[17]), .g6370 (w_core_po[18]), .g6372 (w_core_po[19]),
    .g6374 (w_core_po[20]), .g6728 (w_core_po[21]), .g1290 (w_core_po[22]), .g4121 (w_core_po[23]),
    .g4108 (w_core_po[24]), .g4106 (w_core_po[25]), .g4103 (w_core_po[26]), .g1293 (w_core_po[27]),
    .g4099 (w_core_po[28]), .g4102 (w_core_po[29]), .g4109 (w_core_po[30]), .g4100 (w_core_po[31]),
    .g4112 (w_core_po[32]), .g4105 (w_core_po[33]), .g4101 (w_core_po[34]), .g4110 (w_core_po[35]),
    .g4104 (w_core_po[36]), .g4107 (w_core_po[37]), .g4098 (w_core_po[38])
  );

`ifdef SCAN_LOCKUP_EN
  // Half-cycle retiming so the next chain segment can sample on its own rising edge.
  logic r_lockup;

  always_ff @(negedge CK or negedge rst_n) begin
    if (!rst_n) r_lockup <= 1'b0;
    else        r_lockup <= w_wbr[PO_LAST];
  end

  assign scan_out = r_lockup;
`else
  assign scan_out = w_wbr[PO_LAST];
`endif

endmodule

// File: tb/tb_s9234_scan_top.sv
// Directed bench for s9234_scan_top: reset, functional equivalence, flush, pattern shift, capture/unload.
`define S9234_PINS(PI, PO) \
  .g89(PI[0]), .g94(PI[1]), .g98(PI[2]), .g102(PI[3]), .g107(PI[4]), .g301(PI[5]), \
  .g306(PI[6]), .g310(PI[7]), .g314(PI[8]), .g319(PI[9]), .g557(PI[10]), .g558(PI[11]), \
  .g559(PI[12]), .g560(PI[13]), .g561(PI[14]), .g562(PI[15]), .g563(PI[16]), .g564(PI[17]), \
  .g705(PI[18]), .g639(PI[19]), .g567(PI[20]), .g45(PI[21]), .g42(PI[22]), .g39(PI[23]), \
  .g702(PI[24]), .g32(PI[25]), .g38(PI[26]), .g46(PI[27]), .g36(PI[28]), .g47(PI[29]), \
  .g40(PI[30]), .g37(PI[31]), .g41(PI[32]), .g22(PI[33]), .g44(PI[34]), .g23(PI[35]), \
  .g2584(PO[0]), .g3222(PO[1]), .g3600(PO[2]), .g4307(PO[3]), .g4321(PO[4]), .g4422(PO[5]), \
  .g4809(PO[6]), .g5137(PO[7]), .g5468(PO[8]), .g5469(PO[9]), .g5692(PO[10]), .g6282(PO[11]), \
  .g6284(PO[12]), .g6360(PO[13]), .g6362(PO[14]), .g6364(PO[15]), .g6366(PO[16]), .g6368(PO[17]), \
  .g6370(PO[18]), .g6372(PO[19]), .g6374(PO[20]), .g6728(PO[21]), .g1290(PO[22]), .g4121(PO[23]), \
  .g4108(PO[24]), .g4106(PO[25]), .g4103(PO[26]), .g1293(PO[27]), .g4099(PO[28]), .g4102(PO[29]), \
  .g4109(PO[30]), .g4100(PO[31]), .g4112(PO[32]), .g4105(PO[33]), .g4101(PO[34]), .g4110(PO[35]), \
  .g4104(PO[36]), .g4107(PO[37]), .g4098(PO[38])

module tb_s9234_scan_top;

`ifdef SCAN_LOCKUP_EN
  localparam bit LOCKUP = 1'b1;
`else
  localparam bit LOCKUP = 1'b0;
`endif

  logic        CK;
  logic        rst_n;
  logic        scan_in;
  logic        scan_en;
  logic        scan_out;
  logic [35:0] r_pi;
  logic [38:0] w_po;
  logic [38:0] w_ref_po;

  int n_tests = 0;
  int n_fail  = 0;

  s9234_scan_top dut (
    .CK       (CK),
    .rst_n    (rst_n),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .scan_en  (scan_en),
    `S9234_PINS(r_pi, w_po)
  );

  s9234 u_ref (
    .CK (CK),
    `S9234_PINS(r_pi, w_ref_po)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom()), 32'($urandom())};
  endfunction

  // Advance to 7 time units past the next rising edge (after any lockup update).
  task automatic tick();
    @(posedge CK);
    #7;
  endtask

  logic [38:0] pat_p;
  logic [35:0] pat_q;
  logic [74:0] stream;
  logic [38:0] exp_po;
  logic        exp_bit;

  initial begin
    r_pi = '0; scan_in = 1'b0; scan_en = 1'b0; rst_n = 1'b0;
    pat_p = 39'h5A_C3F0_9E17;
    pat_q = 36'hB_4D29_E6C1;

    // Reset state: scan_out low, and all output cells visible as zero in scan mode
    #3;
    chk("rst_scan_out", {63'd0, scan_out}, 64'd0);
    scan_en = 1'b1;
    #1;
    chk("rst_po_cells", {25'd0, w_po}, 64'd0);
    @(posedge CK); #7;
    rst_n = 1'b1; scan_en = 1'b0;

    // Functional equivalence against a standalone core
    for (int i = 0; i < 300; i++) begin
      r_pi = rand36();
      #1;
      if (i >= 3) chk("equiv", {25'd0, w_po}, {25'd0, w_ref_po});
      tick();
    end

    // Flush of ones from an all-zero chain, PIs toggling underneath
    rst_n = 1'b0; #1; rst_n = 1'b1;
    scan_en = 1'b1; scan_in = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      r_pi = rand36();
      @(posedge CK); #2;
      if (k == 75) chk("flush_edge75_early", {63'd0, scan_out}, {63'd0, !LOCKUP});
      #5;
      chk("flush", {63'd0, scan_out}, (k == 75) ? 64'd1 : 64'd0);
      if (k == 74) chk("flush_po74", {25'd0, w_po}, 64'h3F_FFFF_FFFF);
    end
    chk("flush_po75", {25'd0, w_po}, 64'h7F_FFFF_FFFF);

    // Mid-cycle asynchronous reset
    #1; rst_n = 1'b0; #1;
    chk("async_rst_scan_out", {63'd0, scan_out}, 64'd0);
    chk("async_rst_po", {25'd0, w_po}, 64'd0);
    rst_n = 1'b1;

    // Shift a known 75-bit stream, check PO isolation, then unload it in order
    for (int j = 0; j < 75; j++) stream[j] = (j < 39) ? pat_p[38 - j] : pat_q[j - 39];
    for (int j = 0; j < 75; j++) begin
      scan_in = stream[j];
      r_pi = rand36();
      tick();
    end
    chk("iso_po", {25'd0, w_po}, {25'd0, pat_p});
    chk("iso_scan_out", {63'd0, scan_out}, {63'd0, pat_p[38]});
    r_pi = rand36();
    #1;
    chk("iso_po_pi_change", {25'd0, w_po}, {25'd0, pat_p});
    scan_in = 1'b0;
    for (int k = 1; k < 75; k++) begin
      r_pi = rand36();
      tick();
      chk("unload_stream", {63'd0, scan_out}, {63'd0, stream[k]});
    end

    // Back to functional mode; core rejoins the reference after its pipeline refills
    scan_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r_pi = rand36();
      #1;
      if (i >= 2) chk("equiv_rejoin", {25'd0, w_po}, {25'd0, w_ref_po});
      tick();
    end

    // Capture g89=1, then unload through the whole chain
    r_pi = 36'h1;
    #1;
    exp_po = w_ref_po;
    tick();
    scan_en = 1'b1; scan_in = 1'b0;
    chk("cap_k0", {63'd0, scan_out}, {63'd0, exp_po[38]});
    for (int k = 1; k <= 75; k++) begin
      r_pi = rand36();
      tick();
      if (k <= 38)      exp_bit = exp_po[38 - k];
      else if (k == 74) exp_bit = 1'b1;
      else              exp_bit = 1'b0;
      chk("cap_unload", {63'd0, scan_out}, {63'd0, exp_bit});
      if (k == 74) chk("cap_po74", {25'd0, w_po}, 64'h40_0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`undef S9234_PINS
